// File: rtl/dphy_hsrx_deserializer.sv
// D-PHY HS data-lane receive deserializer: hunts for the SoT sync byte after
// HSRX_EN rises, then assembles LSB-first payload bytes for the protocol layer.
module dphy_hsrx_deserializer #(
  parameter logic [7:0] SYNC_WORD    = 8'hB8,
  parameter int         SYNC_TIMEOUT = 32
) (
  input  logic       HSRX_CLK,
  input  logic       RxRst_n,
  input  logic       HSRX_EN,
  input  logic       HS_Din,
  output logic [7:0] RxDataHS,
  output logic       RxValidHS,
  output logic       RxActiveHS,
  output logic       RxSyncHS,
  output logic       ErrSotSyncHS,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [8:0] TIMEOUT_BITS = 9'(SYNC_TIMEOUT);

  state_t     state;
  logic [7:0] sr;
  logic [7:0] hunt_cnt;
  logic [2:0] bit_cnt;

  logic [7:0] sr_next;
  logic [8:0] hunt_inc;
  logic       sync_hit;
  logic       timeout_hit;

  // Output semantics: RxValidHS/RxSyncHS/ErrSotSyncHS are single-cycle strobes
  // with no backpressure; the consumer must take RxDataHS on the valid cycle.
  assign sr_next     = {HS_Din, sr[7:1]};
  assign hunt_inc    = {1'b0, hunt_cnt} + 9'd1;
  assign sync_hit    = (sr_next == SYNC_WORD) && (hunt_inc >= 9'd8);
  assign timeout_hit = (hunt_inc == TIMEOUT_BITS);
  assign dbg_state   = state;

  always_ff @(posedge HSRX_CLK) begin
    if (!RxRst_n) begin
      state        <= IDLE;
      sr           <= 8'h00;
      hunt_cnt     <= 8'h00;
      bit_cnt      <= 3'd0;
      RxDataHS     <= 8'h00;
      RxValidHS    <= 1'b0;
      RxActiveHS   <= 1'b0;
      RxSyncHS     <= 1'b0;
      ErrSotSyncHS <= 1'b0;
    end else begin
      RxValidHS    <= 1'b0;
      RxSyncHS     <= 1'b0;
      ErrSotSyncHS <= 1'b0;
      // Dropping the enable abandons any partial byte without complaint.
      if (state != IDLE && !HSRX_EN) begin
        state      <= IDLE;
        RxActiveHS <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (HSRX_EN) begin
              state    <= HUNT;
              sr       <= 8'h00;
              hunt_cnt <= 8'h00;
              bit_cnt  <= 3'd0;
            end
          end
          HUNT: begin
            sr <= sr_next;
            if (hunt_cnt != 8'hFF) hunt_cnt <= hunt_inc[7:0];
            if (sync_hit) begin
              state      <= DATA;
              RxSyncHS   <= 1'b1;
              RxActiveHS <= 1'b1;
              bit_cnt    <= 3'd0;
            end else if (timeout_hit) begin
              state        <= ERR;
              ErrSotSyncHS <= 1'b1;
            end
          end
          DATA: begin
            sr      <= sr_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              RxDataHS  <= sr_next;
              RxValidHS <= 1'b1;
            end
          end
          ERR: begin
            state <= ERR;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dphy_hsrx_deserializer.sv
// Directed bench for dphy_hsrx_deserializer: sync hunt, payload assembly,
// timeout, trail discard, mid-packet reset and back-to-back bursts.
module tb_dphy_hsrx_deserializer;

  logic       HSRX_CLK = 1'b0;
  logic       RxRst_n  = 1'b0;
  logic       HSRX_EN  = 1'b0;
  logic       HS_Din   = 1'b0;
  logic [7:0] RxDataHS;
  logic       RxValidHS;
  logic       RxActiveHS;
  logic       RxSyncHS;
  logic       ErrSotSyncHS;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sync_pat = 8'hB8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  always #5 HSRX_CLK = ~HSRX_CLK;

  dphy_hsrx_deserializer #(.SYNC_WORD(8'hB8), .SYNC_TIMEOUT(32)) dut (
    .HSRX_CLK    (HSRX_CLK),
    .RxRst_n     (RxRst_n),
    .HSRX_EN     (HSRX_EN),
    .HS_Din      (HS_Din),
    .RxDataHS    (RxDataHS),
    .RxValidHS   (RxValidHS),
    .RxActiveHS  (RxActiveHS),
    .RxSyncHS    (RxSyncHS),
    .ErrSotSyncHS(ErrSotSyncHS),
    .dbg_state   (dbg_state)
  );

  task automatic tick();
    @(posedge HSRX_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    checks++;
    assert (dbg_state === exp) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, dbg_state, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic e_sync, input logic e_valid,
                          input logic e_err, input logic e_act);
    logic [7:0] e_data;
    HSRX_EN = 1'b1;
    HS_Din  = b;
    tick();
    chk_bit("sync", RxSyncHS, e_sync);
    chk_bit("valid", RxValidHS, e_valid);
    chk_bit("err", ErrSotSyncHS, e_err);
    chk_bit("active", RxActiveHS, e_act);
    if (e_valid) begin
      e_data = 8'h00;
      if (exp_q.size() > 0) e_data = exp_q.pop_front();
      chk("data", RxDataHS, e_data);
    end
  endtask

  task automatic start_hunt();
    HSRX_EN = 1'b1;
    HS_Din  = 1'b1;
    tick();
    chk_state("enter_hunt", ST_HUNT);
    chk_bit("hunt_entry_sync", RxSyncHS, 1'b0);
    chk_bit("hunt_entry_active", RxActiveHS, 1'b0);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sync_pat[i], i == 7, 1'b0, 1'b0, i == 7);
    chk_state("after_sync", ST_DATA);
  endtask

  task automatic send_byte(input logic [7:0] v);
    exp_q.push_back(v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0, i == 7, 1'b0, 1'b1);
  endtask

  task automatic stop_burst(input logic [7:0] held);
    HSRX_EN = 1'b0;
    HS_Din  = 1'b0;
    tick();
    chk_state("stop_idle", ST_IDLE);
    chk_bit("stop_active", RxActiveHS, 1'b0);
    chk_bit("stop_valid", RxValidHS, 1'b0);
    chk_bit("stop_err", ErrSotSyncHS, 1'b0);
    chk("stop_data_hold", RxDataHS, held);
  endtask

  initial begin
    logic [12:0] false_seq;

    // Reset
    RxRst_n = 1'b0;
    tick();
    tick();
    chk_state("reset_state", ST_IDLE);
    chk("reset_data", RxDataHS, 8'h00);
    chk_bit("reset_valid", RxValidHS, 1'b0);
    chk_bit("reset_active", RxActiveHS, 1'b0);
    chk_bit("reset_sync", RxSyncHS, 1'b0);
    chk_bit("reset_err", ErrSotSyncHS, 1'b0);
    RxRst_n = 1'b1;
    tick();
    chk_state("idle_no_en", ST_IDLE);

    // Basic packet
    start_hunt();
    send_preamble();
    send_byte(8'h5A);
    send_byte(8'hC3);
    stop_burst(8'hC3);

    // Early false match: B8 pattern formed after only 5 bits must not sync
    false_seq = 13'b1011100010111;
    start_hunt();
    for (int i = 0; i < 13; i++) send_bit(false_seq[i], i == 12, 1'b0, 1'b0, i == 12);
    send_byte(8'h3C);
    stop_burst(8'h3C);

    // Timeout on the 32nd sampled bit
    start_hunt();
    for (int i = 1; i <= 40; i++) send_bit(1'b0, 1'b0, 1'b0, i == 32, 1'b0);
    chk_state("timeout_err_state", ST_ERR);
    stop_burst(8'h3C);

    // Trail discard
    start_hunt();
    send_preamble();
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    stop_burst(8'hA5);
    tick();
    chk_bit("trail_no_late_valid", RxValidHS, 1'b0);
    chk("trail_data_hold", RxDataHS, 8'hA5);

    // Reset mid-packet
    start_hunt();
    send_preamble();
    send_byte(8'h11);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    RxRst_n = 1'b0;
    HSRX_EN = 1'b1;
    tick();
    chk_state("midrst_state", ST_IDLE);
    chk("midrst_data", RxDataHS, 8'h00);
    chk_bit("midrst_active", RxActiveHS, 1'b0);
    chk_bit("midrst_valid", RxValidHS, 1'b0);
    RxRst_n = 1'b1;
    start_hunt();
    send_preamble();
    send_byte(8'h7E);
    stop_burst(8'h7E);

    // Back-to-back bursts separated by two cycles of HSRX_EN low
    start_hunt();
    send_preamble();
    send_byte(8'h96);
    stop_burst(8'h96);
    tick();
    chk_state("gap_idle", ST_IDLE);
    start_hunt();
    send_preamble();
    send_byte(8'h69);
    send_byte(8'hF0);
    stop_burst(8'hF0);

    chk("exp_queue_drained", 8'(exp_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dphy_hsrx_deserializer.md
# dphy_hsrx_deserializer

High-speed receive deserializer for the MIPI D-PHY data lane, directly downstream of the LP receive FSM. Once that FSM raises HSRX_EN, this block samples the serial HS bit stream, hunts for the SoT sync byte, and then assembles payload bytes LSB-first. It presents them to the protocol layer with valid, active and sync-error indications.

## Interface
- SYNC_WORD, 8'hB8: leader sync byte; value as assembled LSB-first (wire order 0,0,0,1,1,1,0,1).
- SYNC_TIMEOUT, 32: maximum bits sampled in HUNT before declaring sync failure. Legal range 8..255.

- HSRX_CLK  in  1  bit clock; one HS bit is sampled per rising edge.
- RxRst_n  in  1  synchronous, active-low reset.
- HSRX_EN  in  1  HS receive enable from the LP receive FSM; gates all sampling.
- HS_Din  in  1  serial HS data bit.
- RxDataHS  out  8  last assembled payload byte.
- RxValidHS  out  1  one-cycle strobe; RxDataHS is new.
- RxActiveHS  out  1  high from sync detect until HSRX_EN falls.
- RxSyncHS  out  1  one-cycle strobe on sync detection.
- ErrSotSyncHS  out  1  one-cycle strobe on sync timeout.

## Operation
- States: IDLE, HUNT, DATA, ERR.
- Bit sampling:
  - Each sampled bit shifts in at the MSB: sr_next = {HS_Din, sr[7:1]}.
  - Sampling occurs only on edges where HSRX_EN=1.
- **IDLE**: on an edge with HSRX_EN=1, go to HUNT.
  - sr is cleared to 8'h00 and hunt_cnt to 0.
  - The bit present on that edge is not sampled.
- **HUNT**: every edge with HSRX_EN=1 shifts one bit in and increments hunt_cnt (8 bits, saturating).
  - Sync condition: sr_next == SYNC_WORD and hunt_cnt+1 >= 8, i.e. at least 8 bits sampled since HUNT entry. Cleared zeros must never complete a match.
  - On sync, go to DATA. RxSyncHS=1 and RxActiveHS=1 at that same edge, and bit_cnt is cleared to 0.
  - If there is no sync and hunt_cnt+1 == SYNC_TIMEOUT, go to ERR with ErrSotSyncHS=1 for one cycle.
  - Sync takes priority over timeout on the same edge.
- **DATA**: each sampled bit shifts into sr and increments bit_cnt (3 bits, wraps at 8).
  - On the edge where bit_cnt==7: RxDataHS <= sr_next, RxValidHS=1 for one cycle, and bit_cnt wraps to 0.
- **ERR**: no sampling and no strobes. Remain until HSRX_EN falls.
- **HSRX_EN=0** in any non-IDLE state:
  - Next state is IDLE; RxActiveHS <= 0 at that edge.
  - Any partial byte (HS trail bits) is silently discarded; no strobe and no error.
  - RxDataHS holds its last value.
- A bit present on an edge where HSRX_EN=0 is never sampled, even if it would have completed a byte.
- A re-assertion of HSRX_EN starts a fresh hunt from IDLE.

## Timing
- Reset (RxRst_n=0 on an edge): state=IDLE, sr=0, counters=0, RxDataHS=8'h00, and all strobes, RxActiveHS and ErrSotSyncHS =0. This applies mid-packet as well.
- Byte latency: RxDataHS/RxValidHS update at the same edge that samples the byte's 8th bit, and are visible the following cycle.
- The first payload byte's RxValidHS occurs exactly 8 sampled bits after RxSyncHS.
- In continuous DATA, RxValidHS asserts every 8th cycle and is never high on two consecutive edges.
- Strobes are registered, one cycle wide, and never asserted in IDLE or ERR.
- RxActiveHS falls one edge after HSRX_EN is sampled low.
- A stalled HSRX_EN does not occur mid-burst; behaviour there is defined only by the HSRX_EN=0 rule above.

## Test plan
- **Basic packet**: HSRX_EN=1, then 8 zeros, sync bits 0,0,0,1,1,1,0,1, then bytes 8'h5A and 8'hC3 LSB-first.
  - RxSyncHS pulses on the 16th sampled bit.
  - RxValidHS pulses with RxDataHS=5A, then 8 cycles later with C3.
  - RxActiveHS stays high until HSRX_EN falls.
- **Early false match**: first five sampled bits are 1,1,1,0,1.
  - No RxSyncHS, because fewer than 8 bits have been sampled.
  - A later genuine sync is still detected.
- **Timeout**: 40 bits of all-zeros with SYNC_TIMEOUT=32.
  - ErrSotSyncHS pulses once, on the 32nd sampled bit.
  - No RxValidHS afterwards; IDLE is reached after HSRX_EN falls.
- **Trail discard**: after byte 8'hA5, sample 5 more bits, then drop HSRX_EN.
  - No extra RxValidHS; RxActiveHS falls on the next edge; RxDataHS stays A5.
- **Reset mid-packet**: RxRst_n=0 for one edge during DATA after 3 bits of a byte.
  - All outputs go to 0 and the state is IDLE.
  - A following full packet decodes correctly.
- **Back-to-back bursts**: two packets separated by 2 cycles of HSRX_EN=0.
  - Each burst produces exactly one RxSyncHS and its correct byte sequence, with no residue from the first burst.
